demux14_latch: RTL

DEMUX14_LATCH -- requirements
Module: demux14_latch

---
 rtl/demux14_latch.sv | 116 +++++++++++
 1 files changed

// File: rtl/demux14_latch.sv
// demux14_latch: 1-to-4 serial demultiplexer with a debounced pushbutton select.
// The select value {key2,key1} is synchronized, then debounced before it is
// accepted. din is synchronized and routed into c_out[sel_out].
//
// Optional feature macro: DEMUX14_HOLD_EN
//   defined   -> unselected c_out bits keep their last loaded value
//   undefined -> unselected c_out bits are forced to 0
//
// state  | meaning
// -------+-----------------------------------------------------------
// TRACK  | select accepted, din routed into c_out[sel_out] each cycle
// SETTLE | candidate select under debounce, c_out frozen

module demux14_latch #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       key1,
    input  logic       key2,
    output logic [3:0] c_out,
    output logic [1:0] sel_out,
    output logic       upd
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // The cycle that moves TRACK into SETTLE already counts as the first
    // stable sample, and the accepting cycle is the last one, so acceptance
    // fires when the counter has seen DEBOUNCE_CYCLES-2 increments.
    localparam logic [CNT_W-1:0] ACCEPT_AT =
        CNT_W'((DEBOUNCE_CYCLES >= 2) ? (DEBOUNCE_CYCLES - 2) : 0);

    localparam logic [0:0] TRACK  = 1'b0;
    localparam logic [0:0] SETTLE = 1'b1;

    logic             din_s1, din_s2;
    logic             key1_s1, key1_s2;
    logic             key2_s1, key2_s2;
    logic [1:0]       sel_sync;
    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       cand;

    assign sel_sync = {key2_s2, key1_s2};

    // Two-flop synchronizers for the asynchronous data and key inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_s1  <= 1'b0;
            din_s2  <= 1'b0;
            key1_s1 <= 1'b0;
            key1_s2 <= 1'b0;
            key2_s1 <= 1'b0;
            key2_s2 <= 1'b0;
        end else begin
            din_s1  <= din;
            din_s2  <= din_s1;
            key1_s1 <= key1;
            key1_s2 <= key1_s1;
            key2_s1 <= key2;
            key2_s2 <= key2_s1;
        end
    end

    // Select debounce FSM plus channel routing into c_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= TRACK;
            cnt     <= '0;
            cand    <= 2'b00;
            sel_out <= 2'b00;
            upd     <= 1'b0;
            c_out   <= 4'b0000;
        end else begin
            upd <= 1'b0;
            case (state)
                TRACK: begin
                    if (sel_sync == sel_out) begin
`ifdef DEMUX14_HOLD_EN
                        c_out[sel_out] <= din_s2;
`else
                        c_out <= din_s2 ? (4'b0001 << sel_out) : 4'b0000;
`endif
                    end else begin
                        state <= SETTLE;
                        cnt   <= '0;
                        cand  <= sel_sync;
                    end
                end
                SETTLE: begin
                    if (sel_sync == sel_out) begin
                        // bounced back to the accepted value: silently resume
                        state <= TRACK;
                    end else if (sel_sync != cand) begin
                        cand <= sel_sync;
                        cnt  <= '0;
                    end else if (cnt == ACCEPT_AT) begin
                        sel_out <= cand;
                        upd     <= 1'b1;
                        state   <= TRACK;
`ifndef DEMUX14_HOLD_EN
                        // old channel becomes unselected, so it must read 0
                        c_out <= 4'b0000;
`endif
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= TRACK;
            endcase
        end
    end

endmodule
